// File: rtl/rsa_modexp_unit.sv
// Modular exponentiation engine: right-to-left square-and-multiply over a shared
// interleaved shift-add/subtract modular multiplier (WIDTH cycles per multiply).
module rsa_modexp_unit #(
  parameter int WIDTH     = 32,
  parameter int EXP_WIDTH = WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  input  logic [WIDTH-1:0]     modulus,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [WIDTH-1:0]     result
);

  // state  | meaning
  // IDLE   | waiting for start
  // REDUCE | B = base mod n
  // CHECK  | inspect E: finish, multiply or square
  // MUL    | R = R*B mod n
  // SQR    | B = B*B mod n, then E >>= 1
  // DONE   | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, REDUCE, CHECK, MUL, SQR, DONE} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t               state;
  logic [WIDTH-1:0]     n, r, b, acc, mm_a, mm_b;
  logic [EXP_WIDTH-1:0] e;
  logic [CW-1:0]        cnt;
  logic                 err_pend;

  logic [WIDTH:0]   dbl, dbl_red, sum;
  logic [WIDTH-1:0] acc_nxt;

  // One multiplier step: acc stays below n, so every intermediate fits WIDTH+1 bits.
  always_comb begin
    dbl     = {acc, 1'b0};
    dbl_red = (dbl >= {1'b0, n}) ? dbl - {1'b0, n} : dbl;
    sum     = dbl_red + (mm_a[WIDTH-1] ? {1'b0, mm_b} : '0);
    acc_nxt = (sum >= {1'b0, n}) ? WIDTH'(sum - {1'b0, n}) : sum[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      result   <= '0;
      n        <= '0;
      r        <= '0;
      b        <= '0;
      e        <= '0;
      acc      <= '0;
      mm_a     <= '0;
      mm_b     <= '0;
      cnt      <= '0;
      err_pend <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            err      <= 1'b0;
            n        <= modulus;
            acc      <= '0;
            cnt      <= CNT_LAST;
            mm_a     <= base;
            mm_b     <= WIDTH'(1);
            err_pend <= (modulus == '0);
            if (modulus > WIDTH'(1)) begin
              r     <= WIDTH'(1);
              e     <= exponent;
              state <= REDUCE;
            end else begin
              // Trivial modulus: pass through CHECK with E=0 so completion takes one cycle.
              r     <= '0;
              e     <= '0;
              state <= CHECK;
            end
          end
        end
        REDUCE, MUL, SQR: begin
          acc  <= acc_nxt;
          mm_a <= mm_a << 1;
          cnt  <= cnt - CW'(1);
          if (cnt == '0) begin
            acc <= '0;
            cnt <= CNT_LAST;
            if (state == REDUCE) begin
              b     <= acc_nxt;
              state <= CHECK;
            end else if (state == MUL) begin
              r     <= acc_nxt;
              mm_a  <= b;
              mm_b  <= b;
              state <= SQR;
            end else begin
              b     <= acc_nxt;
              e     <= e >> 1;
              state <= CHECK;
            end
          end
        end
        CHECK: begin
          if (e == '0) begin
            result <= r;
            err    <= err_pend;
            done   <= 1'b1;
            state  <= DONE;
          end else if (e[0]) begin
            mm_a  <= r;
            mm_b  <= b;
            state <= MUL;
          end else begin
            mm_a  <= b;
            mm_b  <= b;
            state <= SQR;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_unit.sv
// Bench for rsa_modexp_unit: directed cases at WIDTH=16 plus random regression at
// WIDTH=8 and WIDTH=32 against an arithmetic reference model.
module tb_rsa_modexp_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        st8, st16, st32;
  logic [7:0]  b8, e8, m8, r8;
  logic [15:0] b16, e16, m16, r16;
  logic [31:0] b32, e32, m32, r32;
  logic        busy8, done8, err8;
  logic        busy16, done16, err16;
  logic        busy32, done32, err32;

  rsa_modexp_unit #(.WIDTH(8)) u8 (
    .clk(clk), .reset(reset), .start(st8), .base(b8), .exponent(e8), .modulus(m8),
    .busy(busy8), .done(done8), .err(err8), .result(r8));
  rsa_modexp_unit #(.WIDTH(16)) u16 (
    .clk(clk), .reset(reset), .start(st16), .base(b16), .exponent(e16), .modulus(m16),
    .busy(busy16), .done(done16), .err(err16), .result(r16));
  rsa_modexp_unit #(.WIDTH(32)) u32 (
    .clk(clk), .reset(reset), .start(st32), .base(b32), .exponent(e32), .modulus(m32),
    .busy(busy32), .done(done32), .err(err32), .result(r32));

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_modexp(input int w, input logic [63:0] bs,
                                             input logic [63:0] ex, input logic [63:0] md);
    logic [63:0] rr, bb;
    if (md <= 1) return 0;
    rr = 1;
    bb = bs % md;
    for (int i = 0; i < w; i++) begin
      if (ex[i]) rr = (rr * bb) % md;
      bb = (bb * bb) % md;
    end
    return rr;
  endfunction

  function automatic int ref_latency(input int w, input logic [63:0] ex, input logic [63:0] md);
    int k, m;
    if (md <= 1) return 1;
    k = 0;
    m = 0;
    for (int i = 0; i < w; i++)
      if (ex[i]) begin
        k = i + 1;
        m++;
      end
    return w + k + w * (k + m) + 1;
  endfunction

  task automatic drive(input int w, input logic s, input logic [31:0] bs,
                       input logic [31:0] ex, input logic [31:0] md);
    case (w)
      8:       begin st8 = s;  b8 = bs[7:0];   e8 = ex[7:0];   m8 = md[7:0];   end
      16:      begin st16 = s; b16 = bs[15:0]; e16 = ex[15:0]; m16 = md[15:0]; end
      default: begin st32 = s; b32 = bs;       e32 = ex;       m32 = md;       end
    endcase
  endtask

  function automatic logic get_busy(input int w);
    return (w == 8) ? busy8 : (w == 16) ? busy16 : busy32;
  endfunction
  function automatic logic get_done(input int w);
    return (w == 8) ? done8 : (w == 16) ? done16 : done32;
  endfunction
  function automatic logic get_err(input int w);
    return (w == 8) ? err8 : (w == 16) ? err16 : err32;
  endfunction
  function automatic logic [63:0] get_res(input int w);
    return (w == 8) ? {56'd0, r8} : (w == 16) ? {48'd0, r16} : {32'd0, r32};
  endfunction

  task automatic run_op(input int w, input logic [31:0] bs, input logic [31:0] ex,
                        input logic [31:0] md, input bit poke,
                        output logic [63:0] res_o, output int lat_o);
    logic [63:0] mask, prev;
    int guard, cyc, drops;
    mask = (64'd1 << w) - 1;
    bs = bs & mask[31:0];
    ex = ex & mask[31:0];
    md = md & mask[31:0];
    @(negedge clk);
    guard = 0;
    while (get_busy(w) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) check("idle_wait", 64'(guard), 0);
    prev = get_res(w);
    drive(w, 1'b1, bs, ex, md);
    @(posedge clk);
    #1;
    drive(w, 1'b0, $urandom, $urandom, $urandom);
    check("busy_at_accept", 64'(get_busy(w)), 1);
    check("err_clear_at_accept", 64'(get_err(w)), 0);
    check("result_hold_at_accept", get_res(w), prev);
    cyc = 0;
    drops = 0;
    while (!get_done(w) && cyc < 4000) begin
      if (poke) drive(w, (cyc == 3 || cyc == 20), $urandom, $urandom, $urandom);
      @(posedge clk);
      #1;
      cyc++;
      if (!get_done(w) && get_busy(w) !== 1'b1) drops++;
    end
    drive(w, 1'b0, $urandom, $urandom, $urandom);
    check("latency", 64'(cyc), 64'(ref_latency(w, 64'(ex), 64'(md))));
    check("result", get_res(w), ref_modexp(w, 64'(bs), 64'(ex), 64'(md)));
    check("err", 64'(get_err(w)), 64'(md == 0));
    check("busy_in_done", 64'(get_busy(w)), 1);
    check("busy_hold", 64'(drops), 0);
    res_o = get_res(w);
    lat_o = cyc;
    @(posedge clk);
    #1;
    check("done_one_cycle", 64'(get_done(w)), 0);
    check("busy_after_done", 64'(get_busy(w)), 0);
  endtask

  initial begin
    logic [63:0] res;
    int lat;
    logic [31:0] rb, re, rm;
    reset = 1'b0;
    drive(8, 1'b0, 0, 0, 0);
    drive(16, 1'b0, 0, 0, 0);
    drive(32, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy16), 0);
    check("rst_done", 64'(done16), 0);
    check("rst_err", 64'(err16), 0);
    check("rst_result", 64'(r16), 0);
    @(negedge clk);
    reset = 1'b1;

    run_op(16, 4, 13, 497, 1'b0, res, lat);
    check("d_4_13_497_res", res, 445);
    check("d_4_13_497_lat", 64'(lat), 133);
    run_op(16, 7, 560, 561, 1'b0, res, lat);
    check("d_carmichael_res", res, 1);
    check("d_carmichael_lat", 64'(lat), 235);
    run_op(16, 1000, 1, 7, 1'b0, res, lat);
    check("d_base_ge_mod_res", res, 6);
    run_op(16, 1000, 0, 7, 1'b0, res, lat);
    check("d_exp0_res", res, 1);
    check("d_exp0_lat", 64'(lat), 17);
    run_op(16, 9, 3, 0, 1'b0, res, lat);
    check("d_mod0_res", res, 0);
    check("d_mod0_err", 64'(err16), 1);
    check("d_mod0_lat", 64'(lat), 1);
    run_op(16, 3, 4, 5, 1'b0, res, lat);
    check("d_mod5_res", res, 1);
    check("d_mod5_err_cleared", 64'(err16), 0);
    run_op(16, 77, 9, 1, 1'b0, res, lat);
    check("d_mod1_res", res, 0);
    run_op(16, 2, 100, 1009, 1'b1, res, lat);

    // Reset partway through a long operation.
    run_op(16, 4, 13, 497, 1'b0, res, lat);
    @(negedge clk);
    drive(16, 1'b1, 12345, 16'hFFFF, 65521);
    @(posedge clk);
    #1;
    drive(16, 1'b0, 0, 0, 0);
    repeat (50) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_busy", 64'(busy16), 0);
    check("midrst_done", 64'(done16), 0);
    check("midrst_err", 64'(err16), 0);
    check("midrst_result", 64'(r16), 0);
    @(negedge clk);
    reset = 1'b1;
    run_op(16, 4, 13, 497, 1'b0, res, lat);
    check("post_rst_res", res, 445);

    for (int i = 0; i < 200; i++) begin
      rb = $urandom;
      re = $urandom;
      rm = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
      run_op(8, rb, re, rm, 1'b0, res, lat);
    end
    for (int i = 0; i < 24; i++) begin
      rb = $urandom;
      re = (i < 20) ? ($urandom & 32'hFF) : $urandom;
      rm = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(0, 1)) : $urandom;
      run_op(32, rb, re, rm, 1'b0, res, lat);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
